limn2600_fetch_unit: RTL and testbench
======================================

Name: limn2600_fetch_unit

Overview:
- Instruction fetch stage directly upstream of limn2600_cache. Owns the PC and a tag/valid array shadowing the cache's data array.
- On a hit, delivers the cached word to decode. On a miss, fetches the word from the memory bus, writes it into the cache through the cache's write port, then replays the lookup.
- Handles branch redirects, cache flush and bus faults.

Parameters:
- NUM_ENTRIES, 4096: entries in the cache data array; power of two; must equal the cache's NUM_ENTRIES.
- RESET_PC, 32'hFFFE_1000: PC loaded at reset.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- redirect  in  1  load redirect_pc as next fetch PC
- redirect_pc  in  32  redirect target; bits [1:0] ignored (forced 0)
- flush  in  1  invalidate all tag entries
- inst_valid  out  1  inst_data/inst_pc valid to decode
- inst_ready  in  1  decode accepts instruction
- inst_data  out  32  instruction word
- inst_pc  out  32  address of inst_data
- fault  out  1  bus error on fetch; sticky until redirect
- mem_req  out  1  memory read request
- mem_addr  out  32  word-aligned read address
- mem_ack  in  1  read complete, mem_rdata/mem_err valid this cycle
- mem_rdata  in  32  read data
- mem_err  in  1  bus error qualifier for mem_ack
- cache_we  out  1  to cache we
- cache_addr_in  out  32  to cache addr_in
- cache_data_in  out  32  to cache data_in
- cache_addr_out  out  32  to cache addr_out
- cache_data_out  in  32  from cache data_out; one-cycle read latency

Behaviour:
- Index: idx = hash(addr) & (NUM_ENTRIES-1).
  - hash is the limn2600 address hash, three rounds: x=((x>>16)^x)*32'h045d9f3b; x=((x>>16)^x)*32'h045d9f3b; x=(x>>16)^x.
  - All arithmetic is 32-bit with truncation, so idx matches the cache's internal index bit-for-bit.
- Tag entry: {valid, addr[31:2]}. Valid bits are a flop vector; tag bits may be RAM.
- Hit: tag[idx(pc)].valid && tag[idx(pc)].addr == pc[31:2].
- Reset (rst low, async):
  - pc=RESET_PC, state=LOOKUP, all valid=0.
  - inst_valid, fault, mem_req, cache_we = 0. mem_addr, cache_addr_in, cache_data_in, inst_data, inst_pc = 0.
  - Reset mid-miss abandons the request; a late mem_ack is ignored.
- cache_addr_out = pc in every state, so cache_data_out settles to word[pc] one cycle after pc is stable.
- States:
  - LOOKUP: tag compare. Hit -> DELIVER; miss -> MISS (latch miss_addr=pc).
  - DELIVER:
    - inst_valid=1, inst_data=cache_data_out, inst_pc=pc.
    - Hold while !inst_ready; outputs stay stable because pc is unchanged.
    - On inst_ready: pc+=4 (wraps 32'hFFFF_FFFC -> 0), -> LOOKUP.
    - Throughput is 1 instruction per 2 cycles on hits.
  - MISS:
    - mem_req=1, mem_addr=miss_addr, both held until mem_ack.
    - On mem_ack with !mem_err: latch mem_rdata, -> FILL.
    - On mem_ack with mem_err: -> FAULT.
    - If discard flag set: ignore data/err and -> LOOKUP.
  - FILL (1 cycle):
    - cache_we=1, cache_addr_in=miss_addr, cache_data_in=latched data.
    - tag[idx(miss_addr)] <= {1, miss_addr[31:2]}.
    - -> LOOKUP; the replayed read returns the new word, no same-cycle read/write hazard.
  - FAULT: fault=1, inst_valid=0; wait for redirect.
- Redirect (highest priority, any state):
  - pc <= redirect_pc & ~3.
  - In MISS: keep mem_req/mem_addr until mem_ack, set discard flag, write nothing.
  - In all other states: -> LOOKUP next cycle. FAULT clears fault. FILL still completes its write.
  - Redirect with inst_ready in DELIVER: the current instruction counts as accepted and pc takes redirect_pc, not pc+4.
- flush: clears all valid bits at the edge.
  - A simultaneous FILL write is lost (flush wins).
  - Flush forces DELIVER -> LOOKUP without asserting acceptance; inst_valid drops.
  - Flush in MISS behaves as in redirect (fill discarded), but pc is unchanged.
- cache_we is never asserted outside FILL. mem_req never drops before mem_ack.

Test Plan:
- Cold start: release rst; mem_ack after 3 cycles with rdata=32'hDEAD_BEEF -> one mem_req at mem_addr=32'hFFFE_1000; cache_we pulse with addr_in=32'hFFFE_1000, data_in=32'hDEADBEEF; then inst_valid with inst_pc=32'hFFFE1000, inst_data=32'hDEADBEEF.
- Hit path: fetch 32'h1000 and 32'h1004, redirect to 32'h1000 -> both delivered with no mem_req, at 2-cycle spacing.
- Backpressure: hold inst_ready=0 for 5 cycles in DELIVER -> inst_data/inst_pc stable, pc not advanced, no cache_we.
- Redirect during miss: miss on 32'h2000, redirect to 32'h3001 before ack -> mem_addr stays 32'h2000 until ack; no cache_we for 32'h2000; next mem_addr=32'h3000.
- Bus error: mem_ack with mem_err=1 -> fault=1 and inst_valid=0 until redirect; a subsequent redirect clears fault.
- Flush: after a hit on 32'h1000, pulse flush, refetch 32'h1000 -> mem_req reissued; flush coincident with FILL leaves the entry invalid.

Source files
------------

// File: rtl/limn2600_fetch_unit_if.sv
// limn2600 fetch unit: decode handshake and memory read bus.
// Master is the fetch unit; slave is decode plus the memory side.
interface limn2600_fetch_unit_if;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        fault;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_err;

  modport master (
    output inst_valid, inst_data, inst_pc, fault,
    output mem_req, mem_addr,
    input  inst_ready, mem_ack, mem_rdata, mem_err
  );

  modport slave (
    input  inst_valid, inst_data, inst_pc, fault,
    input  mem_req, mem_addr,
    output inst_ready, mem_ack, mem_rdata, mem_err
  );
endinterface

// File: rtl/limn2600_fetch_unit.sv
// limn2600 instruction fetch stage: PC, tag/valid shadow of the
// cache data array, miss refill over the memory bus.
module limn2600_fetch_unit #(
  parameter int          NUM_ENTRIES = 4096,
  parameter logic [31:0] RESET_PC    = 32'hFFFE_1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect,
  input  logic [31:0]           redirect_pc,
  input  logic                  flush,
  limn2600_fetch_unit_if.master bus,
  output logic                  cache_we,
  output logic [31:0]           cache_addr_in,
  output logic [31:0]           cache_data_in,
  output logic [31:0]           cache_addr_out,
  input  logic [31:0]           cache_data_out
);

  localparam int IW = $clog2(NUM_ENTRIES);

  typedef enum logic [2:0] {
    LOOKUP,
    DELIVER,
    MISS,
    FILL,
    FAULT
  } state_t;

  // Must match the cache's internal index bit-for-bit.
  function automatic logic [31:0] hash32(input logic [31:0] a);
    logic [31:0] x;
    x = a;
    x = ((x >> 16) ^ x) * 32'h045d9f3b;
    x = ((x >> 16) ^ x) * 32'h045d9f3b;
    x = (x >> 16) ^ x;
    return x;
  endfunction

  state_t           state;
  logic [31:0]      pc;
  logic [31:0]      miss_addr;
  logic             discard;
  logic [29:0]      tag_q [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] valid_q;
  logic [IW-1:0]    pc_idx;
  logic [IW-1:0]    fill_idx;
  logic             hit;
  logic [31:0]      redir_pc;

  assign pc_idx   = IW'(hash32(pc));
  assign fill_idx = IW'(hash32(miss_addr));
  assign hit      = valid_q[pc_idx] && (tag_q[pc_idx] == pc[31:2]);
  assign redir_pc = redirect_pc & ~32'h3;

  assign cache_addr_out = pc;
  assign bus.inst_data  = bus.inst_valid ? cache_data_out : 32'h0;

  always_ff @(posedge clk) begin
    if (state == FILL)
      tag_q[fill_idx] <= miss_addr[31:2];
  end

  // Flush wins over a coincident fill.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      valid_q <= '0;
    else if (flush)
      valid_q <= '0;
    else if (state == FILL)
      valid_q[fill_idx] <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= LOOKUP;
      pc             <= RESET_PC;
      miss_addr      <= '0;
      discard        <= 1'b0;
      bus.inst_valid <= 1'b0;
      bus.inst_pc    <= '0;
      bus.fault      <= 1'b0;
      bus.mem_req    <= 1'b0;
      bus.mem_addr   <= '0;
      cache_we       <= 1'b0;
      cache_addr_in  <= '0;
      cache_data_in  <= '0;
    end else begin
      cache_we <= 1'b0;
      unique case (state)
        LOOKUP: begin
          if (redirect) begin
            pc <= redir_pc;
          end else if (flush) begin
            state <= LOOKUP;
          end else if (hit) begin
            state          <= DELIVER;
            bus.inst_valid <= 1'b1;
            bus.inst_pc    <= pc;
          end else begin
            state        <= MISS;
            miss_addr    <= pc;
            discard      <= 1'b0;
            bus.mem_req  <= 1'b1;
            bus.mem_addr <= pc;
          end
        end
        DELIVER: begin
          if (redirect) begin
            pc             <= redir_pc;
            state          <= LOOKUP;
            bus.inst_valid <= 1'b0;
          end else if (flush) begin
            state          <= LOOKUP;
            bus.inst_valid <= 1'b0;
          end else if (bus.inst_ready) begin
            pc             <= pc + 32'd4;
            state          <= LOOKUP;
            bus.inst_valid <= 1'b0;
          end
        end
        MISS: begin
          if (redirect)
            pc <= redir_pc;
          if (redirect || flush)
            discard <= 1'b1;
          if (bus.mem_ack) begin
            bus.mem_req <= 1'b0;
            if (discard || redirect || flush) begin
              state <= LOOKUP;
            end else if (bus.mem_err) begin
              state     <= FAULT;
              bus.fault <= 1'b1;
            end else begin
              state         <= FILL;
              cache_we      <= 1'b1;
              cache_addr_in <= miss_addr;
              cache_data_in <= bus.mem_rdata;
            end
          end
        end
        FILL: begin
          if (redirect)
            pc <= redir_pc;
          state <= LOOKUP;
        end
        FAULT: begin
          if (redirect) begin
            pc        <= redir_pc;
            state     <= LOOKUP;
            bus.fault <= 1'b0;
          end
        end
        default: state <= LOOKUP;
      endcase
    end
  end

endmodule

// File: tb/tb_limn2600_fetch_unit.sv
// Directed bench for limn2600_fetch_unit with a behavioural
// one-cycle-latency cache and a scripted memory responder.
module tb_limn2600_fetch_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        cache_we;
  logic [31:0] cache_addr_in;
  logic [31:0] cache_data_in;
  logic [31:0] cache_addr_out;
  logic [31:0] cache_data_out;

  int checks = 0;
  int errors = 0;
  int req_cnt = 0;
  int we_cnt = 0;
  logic req_q = 1'b0;
  logic [31:0] cmem [logic [31:0]];

  limn2600_fetch_unit_if bus();

  limn2600_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .bus            (bus),
    .cache_we       (cache_we),
    .cache_addr_in  (cache_addr_in),
    .cache_data_in  (cache_data_in),
    .cache_addr_out (cache_addr_out),
    .cache_data_out (cache_data_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cache_data_out <= cmem.exists(cache_addr_out) ?
                      cmem[cache_addr_out] : 32'h0;
    if (cache_we)
      cmem[cache_addr_in] = cache_data_in;
  end

  always @(posedge clk) begin
    if (bus.mem_req && !req_q)
      req_cnt++;
    req_q = bus.mem_req;
    if (cache_we)
      we_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic wait_req();
    int n = 0;
    while (!bus.mem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.mem_req)
      check("req_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!bus.inst_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.inst_valid)
      check("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic ack(input logic [31:0] d, input logic e);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = d;
    bus.mem_err   = e;
    @(negedge clk);
    bus.mem_ack   = 1'b0;
    bus.mem_err   = 1'b0;
  endtask

  task automatic go(input logic [31:0] a);
    redirect    = 1'b1;
    redirect_pc = a;
    @(negedge clk);
    redirect    = 1'b0;
  endtask

  initial begin
    int base;
    rst = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    flush = 1'b0;
    bus.inst_ready = 1'b0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    bus.mem_err = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", bus.inst_valid, 1'b0);
    check("rst_req", bus.mem_req, 1'b0);
    check("rst_we", cache_we, 1'b0);
    check("rst_fault", bus.fault, 1'b0);
    check("rst_pc", cache_addr_out, 32'hFFFE_1000);

    // Cold start miss and refill
    rst = 1'b1;
    @(negedge clk);
    check("cold_req", bus.mem_req, 1'b1);
    check("cold_addr", bus.mem_addr, 32'hFFFE_1000);
    repeat (3) @(negedge clk);
    check("cold_hold", bus.mem_req, 1'b1);
    ack(32'hDEAD_BEEF, 1'b0);
    check("cold_we", cache_we, 1'b1);
    check("cold_we_addr", cache_addr_in, 32'hFFFE_1000);
    check("cold_we_data", cache_data_in, 32'hDEAD_BEEF);
    wait_valid();
    check("cold_pc", bus.inst_pc, 32'hFFFE_1000);
    check("cold_data", bus.inst_data, 32'hDEAD_BEEF);
    check("cold_reqs", req_cnt, 1);

    // Warm 0x1000 and 0x1004
    go(32'h1000);
    wait_req();
    check("w0_addr", bus.mem_addr, 32'h1000);
    ack(32'hA000_1000, 1'b0);
    wait_valid();
    check("w0_pc", bus.inst_pc, 32'h1000);
    bus.inst_ready = 1'b1;
    @(negedge clk);
    bus.inst_ready = 1'b0;
    wait_req();
    check("w1_addr", bus.mem_addr, 32'h1004);
    ack(32'hA000_1004, 1'b0);
    wait_valid();
    check("w1_data", bus.inst_data, 32'hA000_1004);

    // Hit path at 2-cycle spacing
    base = req_cnt;
    bus.inst_ready = 1'b1;
    go(32'h1000);
    check("hit_gap0", bus.inst_valid, 1'b0);
    @(negedge clk);
    check("hit0_valid", bus.inst_valid, 1'b1);
    check("hit0_pc", bus.inst_pc, 32'h1000);
    check("hit0_data", bus.inst_data, 32'hA000_1000);
    @(negedge clk);
    check("hit_gap1", bus.inst_valid, 1'b0);
    @(negedge clk);
    bus.inst_ready = 1'b0;
    check("hit1_valid", bus.inst_valid, 1'b1);
    check("hit1_pc", bus.inst_pc, 32'h1004);
    check("hit1_data", bus.inst_data, 32'hA000_1004);
    check("hit_noreq", req_cnt, base);

    // Backpressure
    base = we_cnt;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", bus.inst_valid, 1'b1);
      check("bp_pc", bus.inst_pc, 32'h1004);
      check("bp_data", bus.inst_data, 32'hA000_1004);
      check("bp_addr", cache_addr_out, 32'h1004);
    end
    check("bp_nowe", we_cnt, base);

    // Redirect during a miss
    go(32'h2000);
    wait_req();
    check("rm_addr", bus.mem_addr, 32'h2000);
    go(32'h3001);
    check("rm_hold", bus.mem_req, 1'b1);
    check("rm_hold_addr", bus.mem_addr, 32'h2000);
    base = we_cnt;
    ack(32'h2222_2222, 1'b0);
    @(negedge clk);
    check("rm_nowe", we_cnt, base);
    wait_req();
    check("rm_next", bus.mem_addr, 32'h3000);
    ack(32'h3333_3333, 1'b0);
    wait_valid();
    check("rm_pc", bus.inst_pc, 32'h3000);
    check("rm_data", bus.inst_data, 32'h3333_3333);

    // Bus error
    go(32'h4000);
    wait_req();
    ack(32'h0, 1'b1);
    check("err_fault", bus.fault, 1'b1);
    check("err_valid", bus.inst_valid, 1'b0);
    repeat (3) @(negedge clk);
    check("err_sticky", bus.fault, 1'b1);
    go(32'h1000);
    check("err_clear", bus.fault, 1'b0);
    @(negedge clk);
    check("err_hit", bus.inst_valid, 1'b1);
    check("err_hit_pc", bus.inst_pc, 32'h1000);

    // Flush, then flush coincident with FILL
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("fl_drop", bus.inst_valid, 1'b0);
    base = req_cnt;
    wait_req();
    check("fl_addr", bus.mem_addr, 32'h1000);
    ack(32'hA000_1000, 1'b0);
    check("fl_fill", cache_we, 1'b1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    wait_req();
    @(negedge clk);
    check("fl_rereq", req_cnt, base + 2);
    check("fl_readdr", bus.mem_addr, 32'h1000);
    ack(32'hA000_1000, 1'b0);
    wait_valid();
    check("fl_pc", bus.inst_pc, 32'h1000);
    check("fl_data", bus.inst_data, 32'hA000_1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp done");
    $fatal(1, "watchdog");
  end
endmodule
